wb_rr_arbiter: RTL
==================

// Module: wb_rr_arbiter
// PURPOSE
//  N-master to 1-slave Wishbone (classic, pipelined-free) round-robin arbiter.
//  Shares one slave port (e.g. RAM or UART) between the CPU fetch and LSU masters, plus future DMA.
//  Sits between the masters and the crossbar slave side.
//  Grant is held for a whole CYC burst, so read-modify-write sequences stay atomic.
// PARAMETERS
//  NUM_MASTERS     2       number of requesting masters (2..8)
//  ADDR_W          32      address width
//  DATA_W          32      data width; SEL width = DATA_W/8
//  TIMEOUT_CYCLES  255     watchdog limit; used only when WB_ARB_TIMEOUT_EN is defined
// PORTS
//  clk        in   1                 system clock
//  reset      in   1                 synchronous, active-high reset
//  m_cyc      in   [NUM_MASTERS]     per-master CYC
//  m_stb      in   [NUM_MASTERS]     per-master STB
//  m_we       in   [NUM_MASTERS]     per-master WE
//  m_adr      in   [NUM_MASTERS][ADDR_W]    per-master address
//  m_dat_w    in   [NUM_MASTERS][DATA_W]    per-master write data
//  m_sel      in   [NUM_MASTERS][DATA_W/8]  per-master byte select
//  m_ack      out  [NUM_MASTERS]     ACK routed to owner only
//  m_err      out  [NUM_MASTERS]     ERR routed to owner only
//  m_dat_r    out  DATA_W            slave read data, broadcast to all masters
//  s_cyc      out  1                 slave CYC
//  s_stb      out  1                 slave STB
//  s_we       out  1                 slave WE
//  s_adr      out  ADDR_W            slave address
//  s_dat_w    out  DATA_W            slave write data
//  s_sel      out  DATA_W/8          slave byte select
//  s_ack      in   1                 slave ACK
//  s_err      in   1                 slave ERR
//  s_dat_r    in   DATA_W            slave read data
//  grant_o    out  [NUM_MASTERS]     one-hot current owner, for debug and perf counters
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, last_owner=NUM_MASTERS-1, s_cyc=s_stb=0, m_ack=m_err=0.
//   Result: master 0 wins first.
//  FSM IDLE:
//   - If any m_cyc is set, pick the first requester after last_owner, cyclic order.
//   - Register the one-hot grant and go to BUSY.
//   - Arbitration to s_cyc takes 1 cycle.
//  FSM BUSY:
//   - s_* = mux(owner m_*); s_cyc/s_stb forced 0 if the owner's are 0.
//   - m_ack[owner]=s_ack, m_err[owner]=s_err, combinationally; all others 0.
//  Release: owner drops m_cyc -> next edge: state=IDLE, grant=0, last_owner=owner.
//   - s_cyc deasserts in the same cycle the owner drops m_cyc (combinational mux).
//   - One idle cycle always separates owners: no back-to-back handover.
//  Grant is never preempted while the owner holds m_cyc, including across multiple STB/ACK beats.
//  Simultaneous requests:
//   - Strict rotation, so with all masters requesting continuously each gets one burst per N bursts.
//  A request that appears while BUSY waits; only the owner's m_cyc is sampled in BUSY.
//  Stray s_ack/s_err in IDLE is ignored and never forwarded.
//  A reset asserted mid-transfer returns to IDLE on that edge.
//   - s_cyc drops the following cycle at the latest.
//   - The slave is expected to tolerate CYC abort.
//  NUM_MASTERS=1: same FSM with trivial selection.
//   - The 1-cycle arbitration latency still applies.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - A counter clears on each s_ack/s_err and counts BUSY cycles with s_stb=1 and no ack.
//   - At TIMEOUT_CYCLES it pulses m_err[owner]=1 for 1 cycle, forces s_cyc=0 that cycle,
//     and goes to IDLE with last_owner updated.
//   - Owner must then drop m_cyc; while it stays high it is treated as a new request in rotation.
//  Undefined: no counter, and a hung slave holds the bus forever. Same ports either way.
// STRUCTURE
//  Package wb_arb_pkg:
//   - typedef enum logic {IDLE, BUSY} arb_state_e.
//   - WB_ADDR_W and WB_DATA_W default constants.
//   - Function rr_next(req, last) returning a one-hot grant.
//  Sub-module rr_pick (combinational rotate-priority encoder):
//   - Inputs: req vector, last_owner.
//   - Output: one-hot winner.
//   - Reused by the crossbar.
// TESTING
//  1. Single master: M0 read 0x0000_0010, slave acks 2 cycles after s_stb.
//     -> s_cyc 1 cycle after m_cyc; m_ack[0]=1 with m_dat_r=slave data; m_ack[1]=0.
//  2. M0 and M1 raise m_cyc in the same cycle after reset.
//     -> M0 granted first; after M0 drops, 1 idle cycle, then M1 granted (grant_o 01 -> 00 -> 10).
//  3. Both masters hammer 4 single-beat writes each.
//     -> grants alternate 0,1,0,1...; no master gets two grants in a row while the other waits.
//  4. M1 holds CYC over a 3-beat RMW (read 0x100, write 0x100, read 0x100) while M0 requests.
//     -> M0 is not granted until M1 drops m_cyc.
//  5. Reset asserted while BUSY with s_stb=1.
//     -> next cycle s_cyc=0, grant_o=0, and M0 has priority after reset.
//  6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks.
//     -> m_err[owner]=1 on the 8th stalled cycle, s_cyc forced 0, FSM in IDLE.
//     Without the macro, the bus stays held.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and crossbar.
// rr_next() is the rotate-priority selection used by rr_pick.
package wb_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  // Returns the one-hot first requester strictly after 'last', wrapping at n (1..8).
  function automatic logic [7:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_next = '0;
    found   = 1'b0;
    for (int unsigned off = 1; off <= 8; off++) begin
      idx = (32'(last) + off) % n;
      if (off <= n && !found && req[idx[2:0]]) begin
        rr_next[idx[2:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: one-hot winner after last_i.
// Shared between the single-slave arbiter and the crossbar.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o
);

  logic [7:0] req8;
  logic [2:0] last3;
  logic [7:0] win8;

  always_comb begin
    req8    = 8'(req_i);
    last3   = 3'(last_i);
    win8    = rr_next(req8, last3, N);
    grant_o = win8[N-1:0];
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic round-robin arbiter; grant held for a whole CYC.
// Define WB_ARB_TIMEOUT_EN to enable the stalled-slave watchdog (TIMEOUT_CYCLES).
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_MASTERS-1:0]                m_cyc,
  input  logic [NUM_MASTERS-1:0]                m_stb,
  input  logic [NUM_MASTERS-1:0]                m_we,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]    m_adr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]    m_dat_w,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]  m_sel,
  output logic [NUM_MASTERS-1:0]                m_ack,
  output logic [NUM_MASTERS-1:0]                m_err,
  output logic [DATA_W-1:0]                     m_dat_r,
  output logic                                  s_cyc,
  output logic                                  s_stb,
  output logic                                  s_we,
  output logic [ADDR_W-1:0]                     s_adr,
  output logic [DATA_W-1:0]                     s_dat_w,
  output logic [DATA_W/8-1:0]                   s_sel,
  input  logic                                  s_ack,
  input  logic                                  s_err,
  input  logic [DATA_W-1:0]                     s_dat_r,
  output logic [NUM_MASTERS-1:0]                grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("wb_rr_arbiter: NUM_MASTERS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_rr_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       owner_idx;
  logic                   busy;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   timeout_hit;

  rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req_i   (m_cyc),
    .last_i  (last_q),
    .grant_o (pick)
  );

  // AND-OR mux keyed by the registered one-hot grant; all zero while IDLE.
  always_comb begin
    owner_idx = '0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_w   = '0;
    s_sel     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        owner_idx = IDX_W'(i);
        s_we      = s_we    | m_we[i];
        s_adr     = s_adr   | m_adr[i];
        s_dat_w   = s_dat_w | m_dat_w[i];
        s_sel     = s_sel   | m_sel[i];
      end
    end
  end

  always_comb begin
    busy      = (state_q == BUSY);
    owner_cyc = busy & (|(m_cyc & grant_q));
    owner_stb = busy & (|(m_stb & grant_q));
    s_cyc     = owner_cyc & ~timeout_hit;
    s_stb     = owner_cyc & owner_stb & ~timeout_hit;
    m_ack     = grant_q & {NUM_MASTERS{busy & s_ack}};
    m_err     = grant_q & {NUM_MASTERS{busy & (s_err | timeout_hit)}};
    m_dat_r   = s_dat_r;
    grant_o   = grant_q;
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            stalled;

  // Down-counter reloads on any slave response; terminal count on the Nth stalled cycle.
  always_comb begin
    stalled     = owner_cyc & owner_stb & ~s_ack & ~s_err;
    timeout_hit = stalled & (to_cnt_q == '0);
    to_cnt_d    = to_cnt_q;
    if (!busy || s_ack || s_err || timeout_hit) begin
      to_cnt_d = TO_LOAD;
    end else if (stalled) begin
      to_cnt_d = to_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= TO_LOAD;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        if (!owner_cyc || timeout_hit) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
